// File: rtl/dist_approx_ctrl_if.sv
// Control bundle between dist_approx_ctrl (master) and the datapath/host side (slave).
// The step input exists only when DPCTL_STEP_EN is defined.
interface dist_approx_ctrl_if;
  logic        start;
  logic [4:0]  load;
  logic [11:0] oe;
  logic [1:0]  c1;
  logic [1:0]  c2;
  logic        busy;
  logic        done;
`ifdef DPCTL_STEP_EN
  logic        step;
`endif

  modport master (
`ifdef DPCTL_STEP_EN
    input  step,
`endif
    input  start,
    output load, oe, c1, c2, busy, done
  );

  modport slave (
`ifdef DPCTL_STEP_EN
    output step,
`endif
    output start,
    input  load, oe, c1, c2, busy, done
  );
endinterface

// File: rtl/dist_approx_ctrl.sv
// Sequencer for the max(x, x - x/8 + y/2) distance-approximation datapath.
// Optional feature: define DPCTL_STEP_EN to gate progress through LOAD..MAX2 with bus.step.
module dist_approx_ctrl #(
  parameter logic [1:0] C1_ABS1 = 2'b00,
  parameter logic [1:0] C1_ABS2 = 2'b01,
  parameter logic [1:0] C1_MIN  = 2'b10,
  parameter logic [1:0] C1_MAX  = 2'b11,
  parameter logic [1:0] C2_ADD  = 2'b00,
  parameter logic [1:0] C2_SUB  = 2'b01,
  parameter logic [1:0] C2_MAX  = 2'b10
) (
  input logic                clk,
  input logic                rst,
  dist_approx_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    StIdle, StLoad, StAbs1, StAbs2, StMax, StMin, StSub, StAdd, StMax2, StDone
  } state_e;

  state_e     state_q, state_d;
  logic       valid_q, valid_d;
  logic       adv;
  logic [4:0] load_raw;

`ifdef DPCTL_STEP_EN
  assign adv = bus.step;
`else
  assign adv = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StLoad;
      StLoad:  if (adv) state_d = StAbs1;
      StAbs1:  if (adv) state_d = StAbs2;
      StAbs2:  if (adv) state_d = StMax;
      StMax:   if (adv) state_d = StMin;
      StMin:   if (adv) state_d = StSub;
      StSub:   if (adv) state_d = StAdd;
      StAdd:   if (adv) state_d = StMax2;
      StMax2:  if (adv) state_d = StDone;
      StDone: begin
        state_d = StIdle;
        valid_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode state_q only; start never reaches them combinationally.
  always_comb begin
    load_raw = '0;
    bus.oe   = '0;
    bus.c1   = '0;
    bus.c2   = '0;
    bus.busy = 1'b1;
    bus.done = 1'b0;
    unique case (state_q)
      StIdle: begin
        bus.busy   = 1'b0;
        bus.oe[10] = valid_q;
      end
      StLoad: begin
        bus.oe[2]   = 1'b1;
        bus.oe[5]   = 1'b1;
        load_raw[0] = 1'b1;
        load_raw[1] = 1'b1;
      end
      StAbs1: begin
        bus.c1      = C1_ABS1;
        bus.oe[0]   = 1'b1;
        bus.oe[3]   = 1'b1;
        load_raw[0] = 1'b1;
      end
      StAbs2: begin
        bus.c1      = C1_ABS2;
        bus.oe[1]   = 1'b1;
        bus.oe[4]   = 1'b1;
        load_raw[1] = 1'b1;
      end
      StMax: begin
        bus.c1      = C1_MAX;
        bus.oe[1]   = 1'b1;
        bus.oe[6]   = 1'b1;
        load_raw[3] = 1'b1;
        load_raw[2] = 1'b1;
      end
      StMin: begin
        bus.c1      = C1_MIN;
        bus.oe[1]   = 1'b1;
        load_raw[4] = 1'b1;
      end
      StSub: begin
        bus.c2      = C2_SUB;
        bus.oe[7]   = 1'b1;
        bus.oe[9]   = 1'b1;
        bus.oe[11]  = 1'b1;
        load_raw[2] = 1'b1;
      end
      StAdd: begin
        bus.c2      = C2_ADD;
        bus.oe[8]   = 1'b1;
        bus.oe[9]   = 1'b1;
        bus.oe[11]  = 1'b1;
        load_raw[2] = 1'b1;
      end
      StMax2: begin
        bus.c2      = C2_MAX;
        bus.oe[7]   = 1'b1;
        bus.oe[9]   = 1'b1;
        bus.oe[11]  = 1'b1;
        load_raw[2] = 1'b1;
      end
      StDone: begin
        bus.busy   = 1'b0;
        bus.oe[10] = 1'b1;
        bus.done   = 1'b1;
      end
      default: bus.busy = 1'b0;
    endcase
  end

  // A stalled cycle keeps the state's enables and modes but must not capture.
  assign bus.load = load_raw & {5{adv}};

endmodule
